core_state_unit: RTL and testbench

//  Parametrised holder of PC, SP, SR and the instruction register, plus a hardware interrupt entry/return sequencer.

---
 rtl/core_state_pkg.sv | 34 +++
 rtl/core_state_unit_irq_priority_encoder.sv | 24 ++
 rtl/core_state_unit.sv | 172 +++++++++++++++++
 tb/tb_core_state_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_state_pkg.sv
// Shared types and constants for the core state unit: PC source select,
// interrupt/return sequencer states and status-register bit positions.
package core_state_pkg;

  typedef enum logic [1:0] {
    REG  = 2'd0,
    MEM  = 2'd1,
    NEXT = 2'd2
  } pc_src_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    PUSH_PC = 4'd1,
    PUSH_SR = 4'd2,
    VECTOR  = 4'd3,
    SR_INC  = 4'd4,
    SR_RD   = 4'd5,
    SR_LD   = 4'd6,
    PC_INC  = 4'd7,
    PC_RD   = 4'd8,
    PC_LD   = 4'd9
  } csu_state_t;

  localparam int unsigned SR_X  = 0;
  localparam int unsigned SR_Z  = 1;
  localparam int unsigned SR_N  = 2;
  localparam int unsigned SR_C  = 3;
  localparam int unsigned SR_V  = 4;
  localparam int unsigned SR_IE = 5;

  // Channel index width; sized for the largest supported channel count (16).
  localparam int unsigned IRQ_IDX_W = 4;

endpackage

// File: rtl/core_state_unit_irq_priority_encoder.sv
// Fixed-priority encoder for the interrupt request lines; bit 0 wins.
module irq_priority_encoder
  import core_state_pkg::*;
#(
  parameter int unsigned IRQ_CHANNELS = 4
) (
  input  logic [IRQ_CHANNELS-1:0] req,
  output logic                    valid,
  output logic [IRQ_IDX_W-1:0]    index
);

  // The first set bit found while scanning upward is kept.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < IRQ_CHANNELS; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        index = IRQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_state_unit.sv
// PC/SP/SR/IR holder with an interrupt entry and return-from-interrupt stack
// sequencer. Optional stack guard enabled by defining CSU_STACK_GUARD_EN.
module core_state_unit
  import core_state_pkg::*;
#(
  parameter int unsigned       WIDTH        = 16,
  parameter int unsigned       IRQ_CHANNELS = 4,
  parameter logic [WIDTH-1:0]  SP_RESET     = 'h8000,
  parameter logic [WIDTH-1:0]  VEC_BASE     = 'h0010,
  parameter logic [WIDTH-1:0]  SP_LIMIT     = 'h7F00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_ir,
  input  logic                    set_pc,
  input  pc_src_t                 pc_src,
  input  logic                    set_sp,
  input  logic                    sp_inc,
  input  logic                    set_flags,
  input  logic                    set_vc,
  input  logic [4:0]              flags_in,
  input  logic                    sr_from_mem,
  input  logic [WIDTH-1:0]        reg_rdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic [IRQ_CHANNELS-1:0] irq_req,
  input  logic                    irq_window,
  input  logic                    rti_start,
  output logic [WIDTH-1:0]        pc,
  output logic [WIDTH-1:0]        sp,
  output logic [WIDTH-1:0]        sr,
  output logic [WIDTH-1:0]        ir,
  output logic                    busy,
  output logic                    mem_we,
  output logic [WIDTH-1:0]        mem_waddr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [WIDTH-1:0]        mem_raddr,
  output logic [IRQ_CHANNELS-1:0] irq_ack,
  output logic                    stack_fault
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef CSU_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  csu_state_t           state_q, state_d;
  logic [IRQ_IDX_W-1:0] ch_q;
  logic                 irq_valid;
  logic [IRQ_IDX_W-1:0] irq_index;
  logic                 push;
  logic                 pop;
  logic                 push_blocked;

  irq_priority_encoder #(
    .IRQ_CHANNELS (IRQ_CHANNELS)
  ) u_prio (
    .req   (irq_req),
    .valid (irq_valid),
    .index (irq_index)
  );

  // RTI is checked first so it beats a simultaneous interrupt entry.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    push      = 1'b0;
    pop       = 1'b0;
    mem_wdata = '0;
    irq_ack   = '0;
    unique case (state_q)
      IDLE: begin
        if (rti_start) begin
          state_d = SR_INC;
        end else if (irq_window && sr[SR_IE] && irq_valid) begin
          state_d = PUSH_PC;
        end
      end
      PUSH_PC: begin
        push      = 1'b1;
        mem_wdata = pc;
        state_d   = PUSH_SR;
      end
      PUSH_SR: begin
        push      = 1'b1;
        mem_wdata = sr;
        state_d   = VECTOR;
      end
      VECTOR: begin
        for (int unsigned i = 0; i < IRQ_CHANNELS; i++) begin
          irq_ack[i] = (ch_q == IRQ_IDX_W'(i));
        end
        state_d = IDLE;
      end
      SR_INC: begin
        pop     = 1'b1;
        state_d = SR_RD;
      end
      SR_RD:  state_d = SR_LD;
      SR_LD:  state_d = PC_INC;
      PC_INC: begin
        pop     = 1'b1;
        state_d = PC_RD;
      end
      PC_RD:  state_d = PC_LD;
      PC_LD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign push_blocked = GUARD_EN && push && (sp < SP_LIMIT);
  assign mem_we       = push && !push_blocked;
  assign mem_waddr    = sp;
  assign mem_raddr    = sp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pc      <= '0;
      sp      <= SP_RESET;
      sr      <= '0;
      ir      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (load_ir) ir <= mem_rdata;
          if (set_pc) begin
            unique case (pc_src)
              REG:     pc <= reg_rdata;
              MEM:     pc <= mem_rdata;
              default: pc <= pc + ONE;
            endcase
          end
          if (set_sp) sp <= sp_inc ? sp + ONE : sp - ONE;
          if (sr_from_mem) begin
            sr <= mem_rdata;
          end else if (set_flags) begin
            sr[SR_N:SR_X] <= flags_in[2:0];
            if (set_vc) sr[SR_V:SR_C] <= flags_in[4:3];
          end
          if (state_d == PUSH_PC) ch_q <= irq_index;
        end
        PUSH_PC, PUSH_SR: sp <= sp - ONE;
        VECTOR: begin
          pc        <= VEC_BASE + WIDTH'(ch_q);
          sr[SR_IE] <= 1'b0;
        end
        SR_INC, PC_INC: sp <= sp + ONE;
        SR_LD: sr <= mem_rdata;
        PC_LD: pc <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef CSU_STACK_GUARD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stack_fault <= 1'b0;
    end else if (push_blocked || (pop && (sp == SP_RESET))) begin
      stack_fault <= 1'b1;
    end
  end
`else
  assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_core_state_unit.sv
// Directed self-checking bench for core_state_unit with a small stack memory model.
module tb_core_state_unit;
  import core_state_pkg::*;

`ifdef CSU_STACK_GUARD_EN
  localparam logic [15:0] TB_LIMIT = 16'h7FFF;
`else
  localparam logic [15:0] TB_LIMIT = 16'h7F00;
`endif

  logic        clock, reset;
  logic        load_ir, set_pc, set_sp, sp_inc, set_flags, set_vc, sr_from_mem;
  pc_src_t     pc_src;
  logic [4:0]  flags_in;
  logic [15:0] reg_rdata, mem_rdata;
  logic [3:0]  irq_req;
  logic        irq_window, rti_start;
  logic [15:0] pc, sp, sr, ir;
  logic        busy, mem_we;
  logic [15:0] mem_waddr, mem_wdata, mem_raddr;
  logic [3:0]  irq_ack;
  logic        stack_fault;

  logic [15:0] mem [0:31];
  logic [15:0] rd_q;
  logic        pre_en;
  logic [4:0]  pre_addr;
  logic [15:0] pre_data;
  logic        ovr;
  logic [15:0] ovr_val;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned bcnt;
  logic [3:0]  ack_acc;

  core_state_unit #(
    .WIDTH        (16),
    .IRQ_CHANNELS (4),
    .SP_RESET     (16'h8000),
    .VEC_BASE     (16'h0010),
    .SP_LIMIT     (TB_LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_ir     (load_ir),
    .set_pc      (set_pc),
    .pc_src      (pc_src),
    .set_sp      (set_sp),
    .sp_inc      (sp_inc),
    .set_flags   (set_flags),
    .set_vc      (set_vc),
    .flags_in    (flags_in),
    .sr_from_mem (sr_from_mem),
    .reg_rdata   (reg_rdata),
    .mem_rdata   (mem_rdata),
    .irq_req     (irq_req),
    .irq_window  (irq_window),
    .rti_start   (rti_start),
    .pc          (pc),
    .sp          (sp),
    .sr          (sr),
    .ir          (ir),
    .busy        (busy),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .irq_ack     (irq_ack),
    .stack_fault (stack_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read data is registered: valid one cycle after the address is presented.
  assign mem_rdata = ovr ? ovr_val : rd_q;
  always @(posedge clock) begin
    if (mem_we) mem[mem_waddr[4:0]] <= mem_wdata;
    if (pre_en) mem[pre_addr] <= pre_data;
    rd_q <= mem[mem_raddr[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    load_ir = 0; set_pc = 0; pc_src = NEXT; set_sp = 0; sp_inc = 0;
    set_flags = 0; set_vc = 0; flags_in = '0; sr_from_mem = 0;
    reg_rdata = '0; irq_req = '0; irq_window = 0; rti_start = 0;
    pre_en = 0; pre_addr = '0; pre_data = '0; ovr = 0; ovr_val = '0;
  endtask

  task automatic load_sr(input logic [15:0] v);
    ovr = 1; ovr_val = v; sr_from_mem = 1;
    tick();
    ovr = 0; sr_from_mem = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    repeat (2) tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_sp", sp, 16'h8000);
    check("rst_sr", sr, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_ack", irq_ack, 4'b0000);
    check("rst_fault", stack_fault, 0);
    reset = 1;
    tick();

    // PC increments
    set_pc = 1; pc_src = NEXT;
    repeat (3) tick();
    set_pc = 0;
    check("pc_next3", pc, 16'h0003);

    // IE clear: request must be ignored
    irq_req = 4'b0001; irq_window = 1;
    tick();
    check("no_ie_busy", busy, 0);
    irq_req = '0; irq_window = 0;

    ovr = 1; ovr_val = 16'hBEEF; load_ir = 1;
    tick();
    load_ir = 0; ovr = 0;
    check("ir_load", ir, 16'hBEEF);

    set_sp = 1; sp_inc = 0;
    tick();
    check("sp_dec", sp, 16'h7FFF);
    sp_inc = 1;
    tick();
    set_sp = 0;
    check("sp_inc", sp, 16'h8000);

    set_flags = 1; flags_in = 5'b11111; set_vc = 0;
    tick();
    check("flags_nzx", sr, 16'h0007);
    flags_in = 5'b10000; set_vc = 1;
    tick();
    check("flags_vc", sr, 16'h0010);
    flags_in = 5'b11111; sr_from_mem = 1; ovr = 1; ovr_val = 16'h00A0;
    tick();
    check("sr_mem_wins", sr, 16'h00A0);
    set_flags = 0; set_vc = 0;

    // Combined strobes: SR from memory and PC from register in one cycle
    ovr_val = 16'h0020; set_pc = 1; pc_src = REG; reg_rdata = 16'h0123;
    tick();
    sr_from_mem = 0; ovr = 0; set_pc = 0;
    check("combo_sr", sr, 16'h0020);
    check("combo_pc", pc, 16'h0123);

    // Interrupt entry, channel 1 wins over channel 2
    irq_req = 4'b0110; irq_window = 1;
    tick();
    check("e_busy", busy, 1);
    check("e_we_pc", mem_we, 1);
    check("e_waddr_pc", mem_waddr, 16'h8000);
    check("e_wdata_pc", mem_wdata, 16'h0123);
    irq_window = 0; irq_req = '0; set_pc = 1; pc_src = NEXT;
    tick();
    check("e_we_sr", mem_we, 1);
    check("e_waddr_sr", mem_waddr, 16'h7FFF);
    check("e_wdata_sr", mem_wdata, 16'h0020);
    check("e_pc_held", pc, 16'h0123);
    tick();
    check("e_ack", irq_ack, 4'b0010);
    check("e_sp_vec", sp, 16'h7FFE);
    check("e_busy3", busy, 1);
    set_pc = 0;
    tick();
    check("e_done", busy, 0);
    check("e_ack_off", irq_ack, 4'b0000);
    check("e_pc", pc, 16'h0011);
    check("e_sr", sr, 16'h0000);
    check("e_sp", sp, 16'h7FFE);
    check("e_mem_pc", mem[0], 16'h0123);
    check("e_mem_sr", mem[31], 16'h0020);

    // Return from interrupt
    rti_start = 1;
    tick();
    rti_start = 0;
    bcnt = busy ? 1 : 0;
    repeat (6) begin
      tick();
      if (busy) bcnt++;
    end
    check("r_cycles", bcnt, 6);
    check("r_busy", busy, 0);
    check("r_sr", sr, 16'h0020);
    check("r_pc", pc, 16'h0123);
    check("r_sp", sp, 16'h8000);

    // RTI beats simultaneous IRQ; IRQ taken at next window
    pre_en = 1; pre_addr = 5'd1; pre_data = 16'h0020;
    tick();
    pre_addr = 5'd2; pre_data = 16'h0200;
    tick();
    pre_en = 0;
    irq_req = 4'b0001; irq_window = 1; rti_start = 1;
    tick();
    rti_start = 0; irq_window = 0;
    ack_acc = irq_ack;
    bcnt = busy ? 1 : 0;
    repeat (6) begin
      tick();
      ack_acc |= irq_ack;
      if (busy) bcnt++;
    end
    check("rw_no_ack", ack_acc, 4'b0000);
    check("rw_cycles", bcnt, 6);
    check("rw_pc", pc, 16'h0200);
    check("rw_sp", sp, 16'h8002);
    check("rw_sr", sr, 16'h0020);
    irq_window = 1;
    tick();
    irq_window = 0;
    check("rw_entry_waddr", mem_waddr, 16'h8002);
    check("rw_entry_wdata", mem_wdata, 16'h0200);
    tick();
    tick();
    check("rw_ack", irq_ack, 4'b0001);
    tick();
    irq_req = '0;
    check("rw_pc_vec", pc, 16'h0010);
    check("rw_sp_end", sp, 16'h8000);

    // Reset during PUSH_SR
    load_sr(16'h0020);
    irq_req = 4'b0100; irq_window = 1;
    tick();
    irq_window = 0;
    tick();
    check("a_in_push_sr", mem_wdata, 16'h0020);
    #2 reset = 0;
    #1;
    check("a_pc", pc, 16'h0000);
    check("a_sp", sp, 16'h8000);
    check("a_sr", sr, 16'h0000);
    check("a_busy", busy, 0);
    check("a_we", mem_we, 0);
    ack_acc = irq_ack;
    repeat (2) begin
      tick();
      ack_acc |= irq_ack;
    end
    reset = 1; irq_req = '0;
    tick();
    ack_acc |= irq_ack;
    check("a_no_ack", ack_acc, 4'b0000);
    check("a_idle", busy, 0);

`ifdef CSU_STACK_GUARD_EN
    // Nested entries with SP_LIMIT = 7FFF: the second entry's pushes are blocked
    load_sr(16'h0020);
    irq_req = 4'b0001; irq_window = 1;
    tick();
    irq_window = 0;
    repeat (3) tick();
    check("g_sp1", sp, 16'h7FFE);
    check("g_nofault", stack_fault, 0);
    load_sr(16'h0020);
    irq_window = 1;
    tick();
    irq_window = 0;
    check("g_we_blocked", mem_we, 0);
    tick();
    check("g_fault", stack_fault, 1);
    check("g_we_blocked2", mem_we, 0);
    repeat (2) tick();
    irq_req = '0;
    check("g_sp2", sp, 16'h7FFC);
    tick();
    check("g_sticky", stack_fault, 1);
    reset = 0;
    #1;
    check("g_reset", stack_fault, 0);
    tick();
    reset = 1;
    tick();
`else
    check("nofault_default", stack_fault, 0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
